// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / debug) arbiter for one synchronous data memory.
// Fixed CPU priority, debug anti-starvation counter, one-cycle read return.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   c_req/we/addr/wdata CPU request; c_gnt, c_rvalid, c_rdata return
//   d_req/we/addr/wdata debug request; d_gnt, d_rvalid, d_rdata return
//   m_en/we/addr/wdata  memory command; m_rdata one cycle after a read
module data_mem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD_C,
    RD_D
  } state_t;

  localparam logic [3:0] STV = 4'(STARVE);

  state_t     state;
  logic [3:0] wcnt;
  logic       starved;
  logic       c_win;
  logic       d_win;

  assign starved = (wcnt >= STV);
  assign c_win   = c_req & ~(d_req & starved);
  assign d_win   = d_req & ~c_win;

  // Grants are gated by rst so they drop the moment reset asserts.
  assign c_gnt = rst & c_win;
  assign d_gnt = rst & d_win;
  assign m_en  = c_gnt | d_gnt;

  always_comb begin
    m_we    = 1'b0;
    m_addr  = c_addr;
    m_wdata = c_wdata;
    unique case (1'b1)
      c_gnt: begin
        m_we = c_we;
      end
      d_gnt: begin
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign c_rvalid = (state == RD_C);
  assign d_rvalid = (state == RD_D);
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      unique case (1'b1)
        c_gnt & ~c_we: state <= RD_C;
        d_gnt & ~d_we: state <= RD_D;
        default:       state <= IDLE;
      endcase
      if (d_req & ~d_gnt) begin
        if (wcnt != 4'hf)
          wcnt <= wcnt + 4'd1;
      end else begin
        wcnt <= '0;
      end
    end
  end

endmodule
